// File: rtl/lfu_tracker.sv
// ============================================================================
// lfu_tracker
// ----------------------------------------------------------------------------
// Least-frequently-used tag tracker. Each request (tag) is looked up against a
// small fully-associative table; the tracker reports hit/miss and which entry
// was used. On a miss against a full table it evicts the entry with the
// lowest frequency count (ties go to the lowest index). Counters saturate.
//
// Optional feature (compile-time macro LFU_DECAY_EN):
//   defined     -> every tick pulse halves all frequency counters (aging).
//                  A tick that arrives while the tracker is busy is remembered
//                  in decay_pending and serviced as soon as it returns to IDLE.
//   not defined -> tick is ignored and counters only saturate.
//
// Ports:
//   clock           in   system clock
//   rst             in   synchronous, active-high reset
//   tick            in   one-cycle aging pulse
//   req_valid       in   access request present
//   req_ready       out  tracker can accept a request this cycle
//   req_tag         in   tag being accessed
//   resp_valid      out  one-cycle pulse, response fields valid
//   resp_hit        out  1 = tag was resident
//   resp_index      out  entry hit or filled
//   resp_evict      out  1 = a valid entry was replaced
//   resp_evict_tag  out  tag removed when resp_evict=1
//
// Timing: request accepted at the edge ending cycle T, lookup in T+1,
// resp_valid in T+2, req_ready again in T+3.
// ============================================================================
module lfu_tracker #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tick,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output logic             resp_evict,
    output logic [TAG_W-1:0] resp_evict_tag
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef LFU_DECAY_EN
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, DECAY} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
`endif

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0] lat_tag;

    // Table storage
    logic             ent_valid [ENTRIES];
    logic [TAG_W-1:0] ent_tag   [ENTRIES];
    logic [CNT_W-1:0] ent_cnt   [ENTRIES];

    // Lookup results (combinational, used only in LOOKUP)
    logic             hit_found;
    logic [IDX_W-1:0] hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;
    logic [CNT_W-1:0] victim_cnt;

    logic accept;

`ifdef LFU_DECAY_EN
    logic decay_pending;
`else
    // tick has no function in this build; keep it visibly consumed.
    logic unused_tick;
    assign unused_tick = tick;
`endif

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
`ifdef LFU_DECAY_EN
    assign req_ready = (state == IDLE) && !decay_pending && !tick;
`else
    assign req_ready = (state == IDLE);
`endif

    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef LFU_DECAY_EN
                if (tick || decay_pending) begin
                    state_nxt = DECAY;
                end else
`endif
                if (accept) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
`ifdef LFU_DECAY_EN
            DECAY:   state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LFU_DECAY_EN
    // ------------------------------------------------------------------------
    // Pending aging request. A tick in IDLE goes straight to DECAY (and any
    // pending request is consumed there), so the flag only ever gets set by
    // ticks that arrive while the tracker is busy. Several such ticks collapse
    // into one decay.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            decay_pending <= 1'b0;
        end else if (state == IDLE) begin
            decay_pending <= 1'b0;
        end else if (tick) begin
            decay_pending <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Request tag latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            lat_tag <= '0;
        end else if (state == IDLE && accept) begin
            lat_tag <= req_tag;
        end
    end

    // ------------------------------------------------------------------------
    // Lookup: first matching valid entry, first invalid entry, and the
    // minimum-count entry. Scanning upward with strict comparisons keeps the
    // lowest index on duplicates and ties.
    // ------------------------------------------------------------------------
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        victim_idx = '0;
        victim_cnt = ent_cnt[0];
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit_found && ent_valid[i] && (ent_tag[i] == lat_tag)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!free_found && !ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_cnt[i] < victim_cnt) begin
                victim_cnt = ent_cnt[i];
                victim_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Table and response registers
    // ------------------------------------------------------------------------
    // NOTE: the table is a handful of flops, not a RAM, and reset must leave
    // it empty so that no stale tag can hit; hence every entry is reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_tag[i]   <= '0;
                ent_cnt[i]   <= '0;
            end
            resp_hit       <= 1'b0;
            resp_index     <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (hit_found) begin
                        if (ent_cnt[hit_idx] != CNT_MAX) begin
                            ent_cnt[hit_idx] <= ent_cnt[hit_idx] + CNT_ONE;
                        end
                        resp_hit   <= 1'b1;
                        resp_index <= hit_idx;
                        resp_evict <= 1'b0;
                    end else if (free_found) begin
                        ent_valid[free_idx] <= 1'b1;
                        ent_tag[free_idx]   <= lat_tag;
                        ent_cnt[free_idx]   <= CNT_ONE;
                        resp_hit            <= 1'b0;
                        resp_index          <= free_idx;
                        resp_evict          <= 1'b0;
                    end else begin
                        ent_tag[victim_idx] <= lat_tag;
                        ent_cnt[victim_idx] <= CNT_ONE;
                        resp_hit            <= 1'b0;
                        resp_index          <= victim_idx;
                        resp_evict          <= 1'b1;
                        resp_evict_tag      <= ent_tag[victim_idx];
                    end
                end
`ifdef LFU_DECAY_EN
                DECAY: begin
                    // Aging touches counts only; valid bits and tags stay.
                    for (int i = 0; i < ENTRIES; i++) begin
                        ent_cnt[i] <= ent_cnt[i] >> 1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
